// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe datapath and its issue controller.
package pipe_pkg;

    localparam int REG_AW = 4;
    localparam int ADDR_W = 8;
    localparam int FUNC_W = 2;

    localparam logic [FUNC_W-1:0] FN_ADD = 2'b00;
    localparam logic [FUNC_W-1:0] FN_SUB = 2'b01;
    localparam logic [FUNC_W-1:0] FN_MUL = 2'b10;
    localparam logic [FUNC_W-1:0] FN_MOV = 2'b11;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HAZ  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_issue_fifo.sv
// Instruction FIFO for the issue controller: QDEPTH entries, head visible combinationally.
module pipe_issue_fifo
    import pipe_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic   clk1,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  instr_t wr_data,
    output instr_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(QDEPTH);

    instr_t        mem_q [QDEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk1) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue controller for the 4-stage pipe: FIFO buffering, RAW scoreboard, bubble insertion.
// Define PIPE_ISSUE_BYPASS_EN when pipe forwards the stage-2 result (only scoreboard entry 0 blocks).
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int QDEPTH   = 4,
    parameter int WB_STAGE = 3,
    parameter int CNT_W    = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              flush,
    output logic              iss_valid,
    output logic [REG_AW-1:0] iss_rs1,
    output logic [REG_AW-1:0] iss_rs2,
    output logic [REG_AW-1:0] iss_rd,
    output logic [FUNC_W-1:0] iss_func,
    output logic [ADDR_W-1:0] iss_addr,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int SB_N = WB_STAGE - 1;
`ifdef PIPE_ISSUE_BYPASS_EN
    localparam int SB_CHK = 1;
`else
    localparam int SB_CHK = SB_N;
`endif

    instr_t                      in_instr, head;
    instr_t                      iss_q, iss_d;
    logic                        iss_valid_q, iss_valid_d;
    logic                        full, empty, push, hazard, issue;
    logic [SB_N-1:0]             sb_v_q, sb_v_d;
    logic [SB_N-1:0][REG_AW-1:0] sb_rd_q, sb_rd_d;
    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;

    assign in_instr = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
    assign in_ready = !rst && !full && !flush;
    assign push     = in_valid && in_ready;

    pipe_issue_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk1    (clk1),
        .rst     (rst),
        .push    (push),
        .pop     (issue),
        .flush   (flush),
        .wr_data (in_instr),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    // Only in-flight producers block; the head never compares against its own rd.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < SB_CHK; k++) begin
            if (sb_v_q[k] && (sb_rd_q[k] == head.rs1 || sb_rd_q[k] == head.rs2)) hazard = 1'b1;
        end
        hazard = hazard && !empty;
    end

    assign issue = !empty && !hazard && !flush;

    always_comb begin
        iss_valid_d = issue;
        iss_d       = issue ? head : iss_q;
        sb_v_d      = sb_v_q;
        sb_rd_d     = sb_rd_q;
        sb_v_d[0]   = issue;
        sb_rd_d[0]  = iss_d.rd;
        for (int k = 1; k < SB_N; k++) begin
            sb_v_d[k]  = sb_v_q[k-1];
            sb_rd_d[k] = sb_rd_q[k-1];
        end

        if (flush || empty) state_d = ST_IDLE;
        else if (hazard)    state_d = ST_HAZ;
        else                state_d = ST_RUN;

        // HAZ marks a cycle whose bubble was caused by a hazard; it is counted as that cycle ends.
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_HAZ && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            sb_v_q      <= '0;
            sb_rd_q     <= '0;
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
            sb_v_q      <= sb_v_d;
            sb_rd_q     <= sb_rd_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_rs1   = iss_q.rs1;
    assign iss_rs2   = iss_q.rs2;
    assign iss_rd    = iss_q.rd;
    assign iss_func  = iss_q.func;
    assign iss_addr  = iss_q.addr;
    assign busy      = !empty || (|sb_v_q);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Scoreboard bench for pipe_issue_ctrl: directed scenarios plus random traffic against a timing model.
module tb_pipe_issue_ctrl;
    import pipe_pkg::*;

    localparam int QDEPTH   = 4;
    localparam int WB_STAGE = 3;
    localparam int CNT_W    = 4;
`ifdef PIPE_ISSUE_BYPASS_EN
    localparam int WIN = 1;
`else
    localparam int WIN = WB_STAGE - 1;
`endif
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic             clk1 = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             flush = 1'b0;
    logic [3:0]       in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [1:0]       in_func = '0;
    logic [7:0]       in_addr = '0;
    logic             in_ready, iss_valid, busy;
    logic [3:0]       iss_rs1, iss_rs2, iss_rd;
    logic [1:0]       iss_func;
    logic [7:0]       iss_addr;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk1 = ~clk1;

    pipe_issue_ctrl #(.QDEPTH(QDEPTH), .WB_STAGE(WB_STAGE), .CNT_W(CNT_W)) dut (
        .clk1(clk1), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
        .flush(flush),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_func(iss_func), .iss_addr(iss_addr),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    // Reference model: in-order issue, each at the earliest cycle allowed by arrival,
    // one-per-cycle throughput and the readiness time of its source registers.
    typedef struct { instr_t ins; int push_e; } exp_t;
    exp_t exp_q[$];
    int   n_cmp = 0, n_err = 0, cyc = 0;
    int   last_t = -100, exp_stall = 0, ready_low = 0;
    int   ready_t[16];

    always @(posedge clk1) cyc <= cyc + 1;

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic void add_stall(int n);
        exp_stall = (exp_stall + n > STALL_MAX) ? STALL_MAX : exp_stall + n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_t    = -100;
        exp_stall = 0;
        foreach (ready_t[r]) ready_t[r] = -100;
    endtask

    // Monitor: pops the model whenever the DUT presents a real instruction.
    exp_t   mon_e;
    int     mon_t, mon_e0;
    instr_t mon_got;
    always @(negedge clk1) begin
        if (!rst && iss_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 32'd1, 32'd0);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_e0  = imax(mon_e.push_e + 1, last_t + 1);
                mon_t   = imax(mon_e0, imax(ready_t[mon_e.ins.rs1], ready_t[mon_e.ins.rs2]));
                add_stall(mon_t - mon_e0);
                mon_got = {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr};
                check("issue_fields", mon_got, mon_e.ins);
                check("issue_cycle", cyc, mon_t);
                check("stall_cnt_at_issue", stall_cnt, exp_stall);
                last_t = mon_t;
                ready_t[mon_e.ins.rd] = mon_t + WIN + 1;
            end
        end
    end

    // One cycle of stimulus; the expected response goes into the model queue.
    task automatic step(input logic v, input instr_t ins, input logic fl, output logic acc);
        int e0;
        @(negedge clk1);
        in_valid = v;
        {in_rs1, in_rs2, in_rd, in_func, in_addr} = ins;
        flush = fl;
        #1;
        check("in_ready", in_ready, (!fl && exp_q.size() < QDEPTH));
        check("busy", busy, (exp_q.size() != 0 || last_t >= cyc - (WB_STAGE - 2)));
        if (v && !in_ready) ready_low++;
        acc = v && in_ready;
        if (fl) begin
            if (exp_q.size() != 0) begin
                e0 = imax(exp_q[0].push_e + 1, last_t + 1);
                if (cyc + 1 > e0) add_stall(cyc + 1 - e0);
            end
            exp_q.delete();
        end
        if (acc) exp_q.push_back('{ins, cyc + 1});
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, acc);
    endtask

    task automatic push_instr(input logic [3:0] rs1, rs2, rd, input logic [1:0] fn, input logic [7:0] ad);
        logic acc;
        int   tries;
        instr_t ins;
        ins   = '{rs1: rs1, rs2: rs2, rd: rd, func: fn, addr: ad};
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 40) begin
            step(1'b1, ins, 1'b0, acc);
            tries++;
        end
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (exp_q.size() != 0 || busy); i++) idle(1);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_busy", busy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst = 1'b1;
        in_valid = 1'b1;
        flush = 1'b0;
        {in_rs1, in_rs2, in_rd} = 12'h5a3;
        @(negedge clk1);
        @(negedge clk1);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_iss_valid", iss_valid, 1'b0);
        check("rst_iss_fields", {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_busy", busy, 1'b0);
        model_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("in_ready_after_reset", in_ready, 1'b1);
    endtask

    initial begin
        logic   acc;
        instr_t r;
        logic [3:0] prev_rd;
        model_reset();

        do_reset();

        // Independent stream: four consecutive issues, no bubbles.
        push_instr(4'd5, 4'd3, 4'd1, FN_ADD, 8'h10);
        push_instr(4'd6, 4'd4, 4'd2, FN_SUB, 8'h11);
        push_instr(4'd7, 4'd5, 4'd3, FN_ADD, 8'h12);
        push_instr(4'd8, 4'd6, 4'd4, FN_SUB, 8'h13);
        drain();
        check("indep_stall_cnt", stall_cnt, 0);

        // Single RAW dependency.
        do_reset();
        push_instr(4'd5, 4'd3, 4'd1, FN_ADD, 8'h20);
        push_instr(4'd1, 4'd4, 4'd2, FN_SUB, 8'h21);
        drain();
        check("raw_stall_cnt", stall_cnt, WIN);

        // Dependency chain backs the FIFO up until it is full.
        do_reset();
        ready_low = 0;
        push_instr(4'd2, 4'd3, 4'd1, FN_MUL, 8'h30);
        prev_rd = 4'd1;
        for (int i = 0; i < 10; i++) begin
            push_instr(prev_rd, prev_rd, 4'(i + 5), FN_MOV, 8'(8'h31 + i));
            prev_rd = 4'(i + 5);
        end
        check("full_backpressure_seen", (ready_low > 0), 1'b1);
        drain();

        // Flush while the head waits on a hazard, with a push offered at the same edge.
        do_reset();
        push_instr(4'd2, 4'd3, 4'd1, FN_ADD, 8'h40);
        push_instr(4'd1, 4'd1, 4'd5, FN_SUB, 8'h41);
        push_instr(4'd5, 4'd4, 4'd6, FN_ADD, 8'h42);
        push_instr(4'd4, 4'd4, 4'd7, FN_MOV, 8'h43);
        step(1'b1, '{rs1: 4'd9, rs2: 4'd9, rd: 4'd9, func: FN_ADD, addr: 8'h44}, 1'b1, acc);
        check("flush_push_dropped", acc, 1'b0);
        idle(1);
        check("flush_bubble", iss_valid, 1'b0);
        drain();
        check("flush_stall_cnt", stall_cnt, exp_stall);

        // Long chain saturates the 4-bit stall counter.
        do_reset();
        prev_rd = 4'd0;
        for (int i = 0; i < 22; i++) begin
            push_instr(prev_rd, prev_rd, 4'((i % 15) + 1), FN_ADD, 8'(i));
            prev_rd = 4'((i % 15) + 1);
        end
        drain();
        check("stall_saturated", stall_cnt, STALL_MAX);

        // Reset in the middle of a stall: nothing queued may issue afterwards.
        push_instr(4'd3, 4'd3, 4'd2, FN_ADD, 8'h50);
        push_instr(4'd2, 4'd2, 4'd3, FN_SUB, 8'h51);
        do_reset();
        idle(6);

        // Random traffic on a small register set to provoke frequent hazards.
        for (int i = 0; i < 400; i++) begin
            r.rs1  = 4'($urandom_range(0, 3));
            r.rs2  = 4'($urandom_range(0, 3));
            r.rd   = 4'($urandom_range(0, 3));
            r.func = 2'($urandom_range(0, 3));
            r.addr = 8'($urandom_range(0, 255));
            step(($urandom % 4) != 0, r, ($urandom % 50) == 0, acc);
        end
        drain();
        check("random_final_stall", stall_cnt, exp_stall);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
